// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates icache (m0) and dcache (m1) onto one system bus.
// One transaction at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate ties between masters.
// Without it, dcache (m1) always wins ties.
// beat_count exposes the 3-bit response beat counter so it can be observed.
module mem_bus_arbiter #(
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  // master 0 (icache)
  input  logic                      m0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
  output logic                      m0_reqack,
  output logic                      m0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
  input  logic                      m0_respack,
  // master 1 (dcache)
  input  logic                      m1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
  output logic                      m1_reqack,
  output logic                      m1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
  input  logic                      m1_respack,
  // system bus
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  // ownership and beat observation
  output logic [1:0]                grant,
  output logic [2:0]                beat_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state;
  logic   pick_m1;
  logic   in_req;
  logic   in_resp;

  assign in_req  = (state == REQ);
  assign in_resp = (state == WAIT) || (state == RESP);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;  // 1 = m1 owned the previous transaction

  // tie goes to the master that did not own the last transaction
  always_comb begin
    if (m0_reqcyc && m1_reqcyc) pick_m1 = ~last_owner;
    else                        pick_m1 = m1_reqcyc;
  end

  // remember who was granted; reset value 0 makes m1 win the first tie
  always_ff @(posedge clk) begin
    if (reset)                                        last_owner <= 1'b0;
    else if (state == IDLE && (m0_reqcyc || m1_reqcyc)) last_owner <= pick_m1;
  end
`else
  // fixed priority: dcache wins every tie
  always_comb pick_m1 = m1_reqcyc;
`endif

  // transaction FSM; grant and the bus request side are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_reqcyc || m1_reqcyc) begin
            state      <= REQ;
            grant      <= pick_m1 ? 2'b10 : 2'b01;
            bus_reqcyc <= 1'b1;
            bus_req    <= pick_m1 ? m1_req    : m0_req;
            bus_reqtag <= pick_m1 ? m1_reqtag : m0_reqtag;
          end
        end
        REQ: begin
          if (bus_reqack) begin
            state      <= WAIT;
            bus_reqcyc <= 1'b0;
          end
        end
        WAIT: begin
          if (bus_respcyc) state <= RESP;
        end
        RESP: begin
          if (!bus_respcyc) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // count accepted response beats; cleared when the burst ends
  always_ff @(posedge clk) begin
    if (reset)                                        beat_count <= 3'd0;
    else if (state == RESP && !bus_respcyc)           beat_count <= 3'd0;
    else if (in_resp && bus_respcyc && bus_respack)   beat_count <= beat_count + 3'd1;
  end

  // steer accept and response beats to the owner only; non-owner sees zeros
  always_comb begin
    m0_reqack   = in_req && grant[0] && bus_reqack;
    m1_reqack   = in_req && grant[1] && bus_reqack;
    m0_respcyc  = in_resp && grant[0] && bus_respcyc;
    m1_respcyc  = in_resp && grant[1] && bus_respcyc;
    m0_resp     = (in_resp && grant[0]) ? bus_resp    : '0;
    m1_resp     = (in_resp && grant[1]) ? bus_resp    : '0;
    m0_resptag  = (in_resp && grant[0]) ? bus_resptag : '0;
    m1_resptag  = (in_resp && grant[1]) ? bus_resptag : '0;
    bus_respack = in_resp && ((grant[0] && m0_respack) || (grant[1] && m1_respack));
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized self-checking bench for mem_bus_arbiter.
// The bench plays both masters and the bus slave; a small model tracks which
// masters have pending requests and who owned the last transaction, and picks
// the expected winner from the tie-break rule.
module tb_mem_bus_arbiter;
  localparam int DW = 64;
  localparam int TW = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [1:0]         rc = '0;
  logic [1:0]         ra = '0;
  logic [1:0][DW-1:0] raddr = '0;
  logic [1:0][TW-1:0] rtag = '0;
  logic [1:0]         ack_o;
  logic [1:0]         rcyc_o;
  logic [1:0][DW-1:0] rdata_o;
  logic [1:0][TW-1:0] rtag_o;

  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack = 1'b0;
  logic          bus_respcyc = 1'b0;
  logic [DW-1:0] bus_resp = '0;
  logic [TW-1:0] bus_resptag = '0;
  logic          bus_respack;
  logic [1:0]    grant;
  logic [2:0]    beat_count;

  int vec = 0;
  int errs = 0;
  int pend[2];
  int model_last;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.BUS_TAG_WIDTH(TW), .BUS_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_reqcyc(rc[0]), .m0_req(raddr[0]), .m0_reqtag(rtag[0]), .m0_reqack(ack_o[0]),
    .m0_respcyc(rcyc_o[0]), .m0_resp(rdata_o[0]), .m0_resptag(rtag_o[0]), .m0_respack(ra[0]),
    .m1_reqcyc(rc[1]), .m1_req(raddr[1]), .m1_reqtag(rtag[1]), .m1_reqack(ack_o[1]),
    .m1_respcyc(rcyc_o[1]), .m1_resp(rdata_o[1]), .m1_resptag(rtag_o[1]), .m1_respack(ra[1]),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .grant(grant), .beat_count(beat_count)
  );

  // expected winner among pending masters
  function automatic int predict();
    if (pend[0] != 0 && pend[1] != 0) begin
`ifdef ARB_ROUND_ROBIN_EN
      return 1 - model_last;
`else
      return 1;
`endif
    end
    return (pend[1] != 0) ? 1 : 0;
  endfunction

  task automatic post_req(input int m, input logic [DW-1:0] a, input logic [TW-1:0] t);
    rc[m] = 1'b1; raddr[m] = a; rtag[m] = t; pend[m] = 1;
  endtask

  // leaves the bench 1 time unit after a negedge in an IDLE cycle
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rc = '0; ra = '0; raddr = '0; rtag = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    pend[0] = 0; pend[1] = 0; model_last = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // one full transaction starting from an IDLE cycle with requests posted
  task automatic run_txn(input int nbeats, input int ack_dly, input int wait_dly, input bit keep,
                         input int late_beat, input logic [DW-1:0] late_addr,
                         output logic [1:0] got_g, output logic [DW-1:0] got_addr);
    int who, oth, nack;
    logic [1:0] exp_g;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    who = predict(); oth = 1 - who; model_last = who; nack = 0;
    exp_g = (who == 1) ? 2'b10 : 2'b01;
    @(negedge clk); #1;
    got_g = grant; got_addr = bus_req;
    vec++; if (grant !== exp_g) begin errs++;
      $display("FAIL grant: got %b want %b", grant, exp_g); end
    vec++; if (bus_reqcyc !== 1'b1 || bus_req !== raddr[who] || bus_reqtag !== rtag[who]) begin errs++;
      $display("FAIL bus_req: cyc %b addr %h tag %h want 1 %h %h", bus_reqcyc, bus_req, bus_reqtag, raddr[who], rtag[who]); end
    repeat (ack_dly) begin
      @(negedge clk); #1;
      vec++; if (bus_reqcyc !== 1'b1 || ack_o !== 2'b00 || grant !== exp_g) begin errs++;
        $display("FAIL req_hold: cyc %b ack %b grant %b want 1 00 %b", bus_reqcyc, ack_o, grant, exp_g); end
    end
    @(negedge clk); bus_reqack = 1'b1; #1;
    vec++; if (ack_o[who] !== 1'b1 || ack_o[oth] !== 1'b0) begin errs++;
      $display("FAIL reqack: got %b want %b", ack_o, exp_g); end
    @(negedge clk);
    bus_reqack = 1'b0;
    if (keep) begin raddr[who] = {$urandom, $urandom}; rtag[who] = TW'($urandom); end
    else begin rc[who] = 1'b0; pend[who] = 0; end
    #1;
    vec++; if (bus_reqcyc !== 1'b0 || rcyc_o !== 2'b00) begin errs++;
      $display("FAIL wait_entry: reqcyc %b respcyc %b want 0 00", bus_reqcyc, rcyc_o); end
    repeat (wait_dly) begin
      @(negedge clk); #1;
      vec++; if (rcyc_o !== 2'b00 || bus_respack !== 1'b0) begin errs++;
        $display("FAIL wait_idle: respcyc %b respack %b want 00 0", rcyc_o, bus_respack); end
    end
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      if (b == late_beat) post_req(1, late_addr, TW'($urandom));
      d = {$urandom, $urandom}; t = TW'($urandom);
      bus_respcyc = 1'b1; bus_resp = d; bus_resptag = t; bus_reqack = 1'($urandom);
      ra[who] = ($urandom_range(0, 3) != 0); ra[oth] = 1'($urandom);
      #1;
      vec++; if (rcyc_o[who] !== 1'b1 || rdata_o[who] !== d || rtag_o[who] !== t) begin errs++;
        $display("FAIL beat_fwd: cyc %b data %h tag %h want 1 %h %h", rcyc_o[who], rdata_o[who], rtag_o[who], d, t); end
      vec++; if (rcyc_o[oth] !== 1'b0 || ack_o !== 2'b00 || bus_respack !== ra[who]) begin errs++;
        $display("FAIL beat_iso: other_cyc %b ack %b respack %b want 0 00 %b", rcyc_o[oth], ack_o, bus_respack, ra[who]); end
      if (ra[who]) nack++;
    end
    @(negedge clk); bus_respcyc = 1'b0; bus_reqack = 1'b0; ra = '0; #1;
    vec++; if (beat_count !== 3'(nack % 8) || rcyc_o !== 2'b00 || grant !== exp_g) begin errs++;
      $display("FAIL burst_end: beats %0d respcyc %b grant %b want %0d 00 %b", beat_count, rcyc_o, grant, nack % 8, exp_g); end
    @(negedge clk); #1;
    vec++; if (grant !== 2'b00 || beat_count !== 3'd0 || bus_reqcyc !== 1'b0) begin errs++;
      $display("FAIL idle: grant %b beats %0d reqcyc %b want 00 0 0", grant, beat_count, bus_reqcyc); end
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if ({grant, bus_reqcyc, bus_respack, ack_o, rcyc_o, beat_count} !== '0) begin errs++;
      $display("FAIL reset_ctl: grant %b reqcyc %b respack %b ack %b respcyc %b beats %0d want all 0",
               grant, bus_reqcyc, bus_respack, ack_o, rcyc_o, beat_count); end
    vec++; if (bus_req !== '0 || bus_reqtag !== '0) begin errs++;
      $display("FAIL reset_bus: addr %h tag %h want 0 0", bus_req, bus_reqtag); end
    // reset must win over live requests
    @(negedge clk); reset = 1'b1; rc = 2'b11; raddr[0] = {$urandom, $urandom}; raddr[1] = {$urandom, $urandom};
    @(negedge clk); #1;
    vec++; if (grant !== 2'b00 || bus_reqcyc !== 1'b0) begin errs++;
      $display("FAIL reset_hold: grant %b reqcyc %b want 00 0", grant, bus_reqcyc); end
    do_reset();
  endtask

  task automatic test_single_m0();
    logic [1:0] g; logic [DW-1:0] a;
    do_reset();
    post_req(0, 64'h1000, 13'h5);
    run_txn(8, 1, 0, 1'b0, -1, '0, g, a);
    vec++; if (g !== 2'b01 || a !== 64'h1000) begin errs++;
      $display("FAIL single_m0: grant %b addr %h want 01 1000", g, a); end
  endtask

  task automatic test_tie();
    logic [1:0] g; logic [DW-1:0] a;
    do_reset();
    post_req(0, 64'hA000, 13'h1);
    post_req(1, 64'hB000, 13'h2);
    run_txn(2, 0, 1, 1'b0, -1, '0, g, a);
    vec++; if (g !== 2'b10 || a !== 64'hB000) begin errs++;
      $display("FAIL tie_first: grant %b addr %h want 10 b000", g, a); end
    run_txn(3, 0, 0, 1'b0, -1, '0, g, a);
    vec++; if (g !== 2'b01 || a !== 64'hA000) begin errs++;
      $display("FAIL tie_second: grant %b addr %h want 01 a000", g, a); end
  endtask

  task automatic test_continuous();
    logic [1:0] g, want; logic [DW-1:0] a;
    do_reset();
    post_req(0, {$urandom, $urandom}, TW'($urandom));
    post_req(1, {$urandom, $urandom}, TW'($urandom));
    for (int i = 0; i < 4; i++) begin
      run_txn(1 + $urandom_range(0, 3), $urandom_range(0, 2), 0, 1'b1, -1, '0, g, a);
`ifdef ARB_ROUND_ROBIN_EN
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      want = 2'b10;
`endif
      vec++; if (g !== want) begin errs++;
        $display("FAIL continuous[%0d]: grant %b want %b", i, g, want); end
    end
    do_reset();
  endtask

  task automatic test_late_request();
    logic [1:0] g; logic [DW-1:0] a;
    do_reset();
    post_req(0, 64'h3000, 13'h7);
    run_txn(8, 0, 0, 1'b0, 3, 64'h2040, g, a);
    run_txn(4, 1, 0, 1'b0, -1, '0, g, a);
    vec++; if (g !== 2'b10 || a !== 64'h2040) begin errs++;
      $display("FAIL late_req: grant %b addr %h want 10 2040", g, a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    post_req(0, 64'h4000, 13'h9);
    @(negedge clk); #1;
    @(negedge clk); bus_reqack = 1'b1;
    @(negedge clk); bus_reqack = 1'b0; rc = '0; #1;
    vec++; if (grant !== 2'b01 || bus_reqcyc !== 1'b0) begin errs++;
      $display("FAIL mid_pre: grant %b reqcyc %b want 01 0", grant, bus_reqcyc); end
    @(negedge clk); reset = 1'b1; pend[0] = 0; pend[1] = 0; model_last = 0;
    @(negedge clk);
    reset = 1'b0; bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom}; bus_resptag = TW'($urandom); ra = 2'b11;
    #1;
    vec++; if ({grant, bus_reqcyc, bus_respack, ack_o, rcyc_o, beat_count} !== '0 || bus_req !== '0) begin errs++;
      $display("FAIL mid_reset: grant %b reqcyc %b respack %b respcyc %b beats %0d addr %h want all 0",
               grant, bus_reqcyc, bus_respack, rcyc_o, beat_count, bus_req); end
    @(negedge clk); #1;
    vec++; if (rcyc_o !== 2'b00 || rdata_o[0] !== '0 || bus_respack !== 1'b0 || beat_count !== 3'd0) begin errs++;
      $display("FAIL mid_after: respcyc %b data %h respack %b beats %0d want 00 0 0 0",
               rcyc_o, rdata_o[0], bus_respack, beat_count); end
    @(negedge clk); bus_respcyc = 1'b0; ra = '0; #1;
  endtask

  task automatic test_random();
    logic [1:0] g; logic [DW-1:0] a;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      for (int m = 0; m < 2; m++)
        if (pend[m] == 0 && $urandom_range(0, 1) == 1) post_req(m, {$urandom, $urandom}, TW'($urandom));
      if (pend[0] == 0 && pend[1] == 0) post_req($urandom_range(0, 1), {$urandom, $urandom}, TW'($urandom));
      run_txn($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), -1, '0, g, a);
    end
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0; model_last = 0;
    test_reset();
    test_single_m0();
    test_tie();
    test_continuous();
    test_late_request();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter BUS_TAG_WIDTH, default 13, SHALL set the tag width on all ports.
REQ-002 Parameter BUS_DATA_WIDTH, default 64, SHALL set the req/resp data width on all ports.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 mN_reqcyc  input  1  SHALL be master N request valid, N=0 (icache) or 1 (dcache), held until mN_reqack.
REQ-006 mN_req  input  BUS_DATA_WIDTH  SHALL be master N request address.
REQ-007 mN_reqtag  input  BUS_TAG_WIDTH  SHALL be master N request tag.
REQ-008 mN_reqack  output  1  SHALL be the request accept to master N.
REQ-009 mN_respcyc  output  1  SHALL be the response beat valid to master N.
REQ-010 mN_resp  output  BUS_DATA_WIDTH  SHALL be the response data to master N.
REQ-011 mN_resptag  output  BUS_TAG_WIDTH  SHALL be the response tag to master N.
REQ-012 mN_respack  input  1  SHALL be the response acknowledge from master N.
REQ-013 bus_reqcyc, bus_req, bus_reqtag, bus_respack  output  1/DATA/TAG/1  SHALL be the system bus request side.
REQ-014 bus_reqack, bus_respcyc, bus_resp, bus_resptag  input  1/1/DATA/TAG  SHALL be the system bus response side.
REQ-015 grant  output  2  SHALL be one-hot current owner (bit N = master N), 0 when idle.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, RESP.
REQ-017 IDLE: if any mN_reqcyc=1, the arbiter SHALL register the winner into grant and enter REQ next cycle; else stay IDLE.
REQ-018 REQ: bus_reqcyc/bus_req/bus_reqtag SHALL be registered copies of the owner's inputs, first asserted the cycle after the IDLE decision (1-cycle arbitration latency).
REQ-019 REQ: bus_reqack=1 SHALL be forwarded combinationally to the owner's mN_reqack, drop bus_reqcyc next cycle, and transition to WAIT.
REQ-020 WAIT: bus_respcyc=1 SHALL transition to RESP; the same-cycle beat SHALL be forwarded.
REQ-021 WAIT/RESP: bus_resp, bus_resptag, bus_respcyc SHALL be forwarded combinationally to the owner only; bus_respack SHALL equal the owner's mN_respack.
REQ-022 RESP: bus_respcyc=0 SHALL return the FSM to IDLE and clear grant next cycle.
REQ-023 A 3-bit beat counter SHALL increment on each bus_respcyc&&bus_respack beat and clear on entering IDLE; it wraps after 8 beats (one 512-bit line).
REQ-024 The non-owner SHALL see mN_reqack=0, mN_respcyc=0, and its request SHALL remain pending without loss.
REQ-025 Simultaneous requests in IDLE SHALL be resolved per REQ-030/031; the loser SHALL be granted in the next IDLE cycle.
REQ-026 Ownership SHALL not change between REQ entry and return to IDLE, even if the owner deasserts mN_reqcyc.
REQ-027 Back-to-back: one IDLE cycle SHALL separate consecutive transactions.

Reset
REQ-028 Reset SHALL force state IDLE, grant=0, bus_reqcyc=0, bus_respack=0, bus_req=0, bus_reqtag=0, beat counter=0, last-owner=0, all mN_reqack/mN_respcyc=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it; bus beats arriving afterward SHALL not be forwarded until a new grant.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, ties SHALL go to the master that did not own the last transaction (after reset: m1).
REQ-031 Without ARB_ROUND_ROBIN_EN, ties SHALL always go to m1 (dcache) fixed priority; last-owner register SHALL be absent.

Verification
REQ-032 m0 read addr 0x1000, bus_reqack after 2 cycles, 8 beats -> grant=01, bus_req=0x1000 one cycle after m0_reqcyc, m0 receives 8 beats, m1_respcyc=0, IDLE after respcyc drops.
REQ-033 m0 and m1 request same cycle after reset -> m1 granted first; m0 granted in the next IDLE.
REQ-034 Round-robin on: both continuously requesting for 4 transactions -> grants alternate 10,01,10,01; without macro -> 10,10,10,10.
REQ-035 m1 requests while m0 in RESP beat 3 -> m1_reqack stays 0 until m0 burst ends, then m1 granted, request 0x2040 intact.
REQ-036 Reset asserted in WAIT -> next cycle all outputs zero, state IDLE; later bus_respcyc pulse not forwarded.
